// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encodings, parity-mode constants and the parity helper
// shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Parity bit for a data word; narrower words are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO holding words waiting to be serialised.
// Pointers carry one extra wrap bit so full and empty need no separate counter.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers, wrapping naturally at 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter with optional parity and 1 or 2 stop bits.
//
// state | meaning
// IDLE  | line high, waiting for a queued word
// START | start bit (low) on the line
// DATA  | data bits, LSB first
// PAR   | parity bit (only when parity is enabled)
// STOP  | stop bit(s) (high); chains straight into START if more words are queued
//
// tx_pin is registered from the current state, so the line lags the FSM by
// one clock; every bit still lasts exactly CYCLE clocks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 20000000,
  parameter int BAUD_RATE  = 57600,
  parameter int BIT        = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [BIT-1:0] tx_data,
  input  logic           tx_data_valid,
  output logic           tx_data_ready,
  output logic           tx_busy,
  output logic           tx_pin
);

  localparam int CYCLE = CLK_FREQ / BAUD_RATE;
  localparam int CW    = (CYCLE < 2) ? 1 : $clog2(CYCLE);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CYCLE - 1);
  localparam logic [2:0]    DATA_LAST = 3'(BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  if (CYCLE < 2) begin : g_chk_cycle
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (BIT < 5 || BIT > 8) begin : g_chk_bit
    $error("uart_tx: BIT must be in 5..8");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_chk_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two, at least 2");
  end

  uart_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [BIT-1:0] shift_q, shift_d;
  logic           par_q, par_d;
  logic           pin_q, pin_d;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BIT-1:0] fifo_rdata;
  logic           bit_end;

  assign bit_end       = (cnt_q == CNT_LAST);
  assign tx_data_ready = !fifo_full;
  assign fifo_push     = tx_data_valid && tx_data_ready;
  assign tx_pin        = pin_q;

  uart_tx_fifo #(
    .WIDTH (BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: each non-idle state lasts whole bit periods.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && bit_q == DATA_LAST)
                 state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
      PAR:     if (bit_end) state_d = STOP;
      STOP:    if (bit_end && bit_q == STOP_LAST)
                 state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: FIFO pop on entry to START, next line level, busy flag.
  always_comb begin
    fifo_pop = (state_d == START) && (state_q != START);
    tx_busy  = (state_q != IDLE) || !fifo_empty;
    pin_d    = 1'b1;
    unique case (state_q)
      START:   pin_d = 1'b0;
      DATA:    pin_d = shift_q[0];
      PAR:     pin_d = par_q;
      default: pin_d = 1'b1;
    endcase
  end

  // Datapath next values: counters clear on every state change, shifter loads on pop.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_d != state_q || bit_end || state_q == IDLE) cnt_d = '0;
    if (state_d != state_q) begin
      bit_d = '0;
    end else if (bit_end && (state_q == DATA || state_q == STOP)) begin
      bit_d = bit_q + 1'b1;
    end
    if (fifo_pop) begin
      shift_d = fifo_rdata;
      par_d   = parity_bit(8'(fifo_rdata), PARITY);
    end else if (state_q == DATA && bit_end) begin
      shift_d = {1'b0, shift_q[BIT-1:1]};
    end
  end

  // Datapath registers, including the registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pin_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pin_q   <= pin_d;
    end
  end

endmodule
